// File: rtl/pkmc_flashprog_if.sv
// pkmc_flashprog_if
//   Request port between the flash program/erase sequencer and the PKMC
//   flash controller.
//   master (sequencer side): drives m_addr_o, m_dat_o, m_we_o, m_active_o,
//                            m_sel_o; receives m_dat_i, m_ack_i.
//   slave  (controller side): the mirror image.
interface pkmc_flashprog_if;
  logic [31:0] m_addr_o;    // word-aligned flash address
  logic [31:0] m_dat_o;     // command or data word
  logic [31:0] m_dat_i;     // read data back from the controller
  logic        m_we_o;      // 1 = write transaction
  logic        m_active_o;  // transaction request
  logic [3:0]  m_sel_o;     // byte select
  logic        m_ack_i;     // transaction acknowledge

  modport master (
    output m_addr_o, m_dat_o, m_we_o, m_active_o, m_sel_o,
    input  m_dat_i, m_ack_i
  );

  modport slave (
    input  m_addr_o, m_dat_o, m_we_o, m_active_o, m_sel_o,
    output m_dat_i, m_ack_i
  );
endinterface

// File: rtl/pkmc_flashprog.sv
// pkmc_flashprog
//   Command sequencer for a 32-bit flash bank built from two x16 Intel-style
//   devices. One start strobe runs a complete read-array, program, block
//   erase or status-read sequence, polls status until ready (or timeout),
//   then restores read-array mode and reports the result.
//
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   start_i    : launch strobe, ignored while busy_o
//   op_i       : 00 read-array, 01 program, 10 erase, 11 read status
//   addr_i     : target byte address (bits [1:0] ignored)
//   wdata_i    : program data
//   busy_o     : sequence in progress
//   done_o     : one-cycle completion pulse
//   err_o      : last op failed (device error or timeout)
//   tmo_o      : last op ended by poll timeout
//   status_o   : last status read {high SR[7:0], low SR[7:0]}
//   bus        : master side of the controller request port
module pkmc_flashprog #(
  parameter logic [23:0] POLL_LIMIT = 24'd16000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [1:0]              op_i,
  input  logic [31:0]             addr_i,
  input  logic [31:0]             wdata_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    tmo_o,
  output logic [15:0]             status_o,
  pkmc_flashprog_if.master        bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] XFER  = 3'd1;
  localparam logic [2:0] GAP   = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  // Step pointer: which transaction of the sequence is current.
  localparam logic [2:0] STEP_CMD  = 3'd0;  // first command (40/20/70)
  localparam logic [2:0] STEP_DATA = 3'd1;  // program data or erase confirm
  localparam logic [2:0] STEP_POLL = 3'd2;  // status read
  localparam logic [2:0] STEP_CLR  = 3'd3;  // clear status
  localparam logic [2:0] STEP_FF   = 3'd4;  // back to read array (always last)

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;
  localparam logic [1:0] OP_STAT  = 2'd3;

  // Commands go to both x16 devices at once.
  function automatic logic [31:0] cmdWord(input logic [7:0] c);
    return {8'h00, c, 8'h00, c};
  endfunction

  logic [2:0]  state;
  logic [2:0]  step;
  logic [1:0]  opReg;
  logic [31:0] wdataReg;
  logic [31:0] addrReg;
  logic [31:0] datReg;
  logic        weReg;
  logic        activeReg;
  logic [23:0] pollCnt;
  logic [15:0] statusReg;
  logic        errReg;
  logic        tmoReg;

  logic        startAccept;
  logic        srReady;
  logic        srError;
  logic [2:0]  nextStep;
  logic        setErr;
  logic        setTmo;
  logic [1:0]  loadOp;
  logic [2:0]  loadStep;
  logic [31:0] loadDat;
  logic        loadWe;
  logic        unusedBits;

  // A new op may be launched in the DONE cycle as well as from IDLE.
  assign startAccept = start_i && ((state == IDLE) || (state == DONE));

  // Both devices must report ready; an error bit in either one fails the op.
  assign srReady = statusReg[7] & statusReg[15];
  assign srError = |{statusReg[13:11], statusReg[9], statusReg[5:3], statusReg[1]};

  // Step sequencing, evaluated during the one-cycle gap (GAP or CHECK).
  always_comb begin
    nextStep = STEP_FF;
    setErr   = 1'b0;
    setTmo   = 1'b0;
    if (state == CHECK) begin
      if (opReg == OP_STAT) begin
        nextStep = STEP_FF;
      end else if (srReady) begin
        if (srError) begin
          nextStep = STEP_CLR;
          setErr   = 1'b1;
        end
      end else if (pollCnt >= POLL_LIMIT) begin
        nextStep = STEP_CLR;
        setErr   = 1'b1;
        setTmo   = 1'b1;
      end else begin
        nextStep = STEP_POLL;
      end
    end else begin
      case (step)
        STEP_CMD:  nextStep = (opReg == OP_STAT) ? STEP_POLL : STEP_DATA;
        STEP_DATA: nextStep = STEP_POLL;
        default:   nextStep = STEP_FF;
      endcase
    end
  end

  // Transaction contents for the step about to be launched. At start time
  // the op comes straight from op_i; the data step only occurs later, so
  // the registered write data is always valid when it is used.
  assign loadOp   = startAccept ? op_i : opReg;
  assign loadStep = startAccept ? ((op_i == OP_READ) ? STEP_FF : STEP_CMD) : nextStep;

  always_comb begin
    loadDat = 32'h0;
    loadWe  = 1'b1;
    case (loadStep)
      STEP_CMD: begin
        case (loadOp)
          OP_PROG:  loadDat = cmdWord(8'h40);
          OP_ERASE: loadDat = cmdWord(8'h20);
          default:  loadDat = cmdWord(8'h70);
        endcase
      end
      STEP_DATA: loadDat = (loadOp == OP_PROG) ? wdataReg : cmdWord(8'hD0);
      STEP_POLL: loadWe  = 1'b0;
      STEP_CLR:  loadDat = cmdWord(8'h50);
      default:   loadDat = cmdWord(8'hFF);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      step      <= STEP_FF;
      opReg     <= OP_READ;
      wdataReg  <= 32'h0;
      addrReg   <= 32'h0;
      datReg    <= 32'h0;
      weReg     <= 1'b0;
      activeReg <= 1'b0;
      pollCnt   <= 24'h0;
      statusReg <= 16'h0;
      errReg    <= 1'b0;
      tmoReg    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (startAccept) begin
            opReg     <= op_i;
            wdataReg  <= wdata_i;
            addrReg   <= {addr_i[31:2], 2'b00};
            pollCnt   <= 24'h0;
            errReg    <= 1'b0;
            tmoReg    <= 1'b0;
            step      <= loadStep;
            datReg    <= loadDat;
            weReg     <= loadWe;
            activeReg <= 1'b1;
            state     <= XFER;
          end else begin
            state <= IDLE;
          end
        end
        XFER: begin
          // Request is held unchanged until acknowledged.
          if (bus.m_ack_i) begin
            activeReg <= 1'b0;
            if (step == STEP_FF) begin
              state <= DONE;
            end else if (!weReg) begin
              statusReg <= {bus.m_dat_i[23:16], bus.m_dat_i[7:0]};
              pollCnt   <= pollCnt + 24'd1;
              state     <= CHECK;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP, CHECK: begin
          // This cycle is the mandatory idle gap between transactions.
          step      <= loadStep;
          datReg    <= loadDat;
          weReg     <= loadWe;
          activeReg <= 1'b1;
          state     <= XFER;
          if (setErr) errReg <= 1'b1;
          if (setTmo) tmoReg <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o   = (state == XFER) || (state == GAP) || (state == CHECK);
  assign done_o   = (state == DONE);
  assign err_o    = errReg;
  assign tmo_o    = tmoReg;
  assign status_o = statusReg;

  assign bus.m_addr_o   = addrReg;
  assign bus.m_dat_o    = datReg;
  assign bus.m_we_o     = weReg;
  assign bus.m_active_o = activeReg;
  assign bus.m_sel_o    = 4'hF;

  // Address LSBs and the upper byte of each x16 status word carry nothing.
  assign unusedBits = ^{addr_i[1:0], bus.m_dat_i[31:24], bus.m_dat_i[15:8]};

endmodule

// File: tb/tb_pkmc_flashprog.sv
// tb_pkmc_flashprog
//   Self-checking bench for pkmc_flashprog. A flash-controller responder
//   acks requests after a programmable delay, serves status words from a
//   queue and records every transaction; a reference model derives the
//   expected transaction list and result flags from the command rules.
module tb_pkmc_flashprog;

  localparam logic [23:0] TB_POLL = 24'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        tmo_o;
  logic [15:0] status_o;

  pkmc_flashprog_if bus();

  pkmc_flashprog #(.POLL_LIMIT(TB_POLL)) dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .op_i     (op_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .err_o    (err_o),
    .tmo_o    (tmo_o),
    .status_o (status_o),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
  } txn_t;

  txn_t        obsQ[$];
  txn_t        expQ[$];
  logic [31:0] statQ[$];     // status words still to be served
  logic [31:0] stimStat[$];  // status words for the current op
  int          compared = 0;
  int          mismatched = 0;
  int          ackDelay = 2;
  int          protoErrs = 0;
  int          cyc = 0;
  int          lastAckCyc = 0;
  int          doneLatency = 0;
  logic        expErr;
  logic        expTmo;
  logic [15:0] expStatus = 16'h0;

  function automatic logic [31:0] cmdw(input logic [7:0] c);
    return {8'h00, c, 8'h00, c};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Responder: acks each request ackDelay cycles after it appears, checks
  // the one-cycle gap and that the request is held stable while pending.
  txn_t cur;
  bit   inTxn = 1'b0;
  bit   havePrev = 1'b0;
  int   gapCnt = 0;
  int   waitCnt = 0;

  initial begin
    bus.m_ack_i = 1'b0;
    bus.m_dat_i = 32'hFFFF_FFFF;
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      bus.m_ack_i = 1'b0;
      bus.m_dat_i = 32'hFFFF_FFFF;
      inTxn = 1'b0;
      havePrev = 1'b0;
      gapCnt = 0;
      waitCnt = 0;
    end else begin
      if (bus.m_ack_i) begin
        bus.m_ack_i = 1'b0;
        bus.m_dat_i = 32'hFFFF_FFFF;
        inTxn = 1'b0;
        havePrev = 1'b1;
        gapCnt = 0;
      end
      if (bus.m_active_o) begin
        if (!inTxn) begin
          if (havePrev && gapCnt != 1) protoErrs++;
          inTxn = 1'b1;
          waitCnt = 0;
          cur = '{we: bus.m_we_o, addr: bus.m_addr_o, dat: bus.m_dat_o};
        end else if (cur.we !== bus.m_we_o || cur.addr !== bus.m_addr_o ||
                     cur.dat !== bus.m_dat_o) begin
          protoErrs++;
        end
        if (waitCnt >= ackDelay) begin
          bus.m_ack_i = 1'b1;
          if (!bus.m_we_o) begin
            if (statQ.size() > 0) bus.m_dat_i = statQ.pop_front();
            else bus.m_dat_i = 32'h0;
          end
          obsQ.push_back(cur);
          lastAckCyc = cyc;
        end else begin
          waitCnt++;
        end
      end else if (havePrev) begin
        gapCnt++;
      end
      if (done_o) begin
        havePrev = 1'b0;
        doneLatency = cyc - lastAckCyc;
      end
    end
  end

  task automatic pushExp(input logic we, input logic [31:0] a, input logic [31:0] d);
    expQ.push_back('{we: we, addr: a, dat: d});
  endtask

  // Reference model: expected transactions and results from the op rules.
  task automatic buildExpected(input logic [1:0] op, input logic [31:0] addr,
                               input logic [31:0] wdata);
    logic [31:0] a;
    logic [31:0] s;
    int          n;
    bit          fin;
    a = {addr[31:2], 2'b00};
    expQ.delete();
    expErr = 1'b0;
    expTmo = 1'b0;
    if (op == 2'd0) begin
      pushExp(1'b1, a, cmdw(8'hFF));
    end else begin
      if (op == 2'd3) begin
        pushExp(1'b1, a, cmdw(8'h70));
        pushExp(1'b0, a, 32'h0);
        s = (stimStat.size() > 0) ? stimStat[0] : 32'h0;
        expStatus = {s[23:16], s[7:0]};
      end else begin
        pushExp(1'b1, a, (op == 2'd1) ? cmdw(8'h40) : cmdw(8'h20));
        pushExp(1'b1, a, (op == 2'd1) ? wdata : cmdw(8'hD0));
        n = 0;
        fin = 1'b0;
        while (!fin) begin
          s = (n < stimStat.size()) ? stimStat[n] : 32'h0;
          pushExp(1'b0, a, 32'h0);
          n++;
          expStatus = {s[23:16], s[7:0]};
          if (s[7] && s[23]) begin
            fin = 1'b1;
            expErr = ((s & 32'h003A_003A) != 32'h0);
          end else if (n == int'(TB_POLL)) begin
            fin = 1'b1;
            expErr = 1'b1;
            expTmo = 1'b1;
          end
        end
      end
      if (expErr) pushExp(1'b1, a, cmdw(8'h50));
      pushExp(1'b1, a, cmdw(8'hFF));
    end
  endtask

  // Run one op; extraAt >= 0 fires a second start that many cycles in.
  task automatic runOp(input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input int delay, input int extraAt);
    bit got;
    int protoBase;
    int nCmp;
    statQ = stimStat;
    obsQ.delete();
    ackDelay = delay;
    protoBase = protoErrs;
    buildExpected(op, addr, wdata);
    @(negedge clk);
    start_i = 1'b1;
    op_i = op;
    addr_i = addr;
    wdata_i = wdata;
    @(negedge clk);
    start_i = 1'b0;
    op_i = 2'($urandom);
    addr_i = $urandom;
    wdata_i = $urandom;
    check("busy_after_start", 32'(busy_o), 32'd1);
    check("active_after_start", 32'(bus.m_active_o), 32'd1);
    got = 1'b0;
    for (int k = 0; k < 600 && !got; k++) begin
      if (done_o) begin
        got = 1'b1;
      end else begin
        if (k == extraAt) begin
          start_i = 1'b1;
          op_i = 2'd0;
        end
        @(negedge clk);
        start_i = 1'b0;
      end
    end
    check("done_seen", 32'(got), 32'd1);
    check("busy_at_done", 32'(busy_o), 32'd0);
    check("err", 32'(err_o), 32'(expErr));
    check("tmo", 32'(tmo_o), 32'(expTmo));
    check("status", 32'(status_o), 32'(expStatus));
    @(negedge clk);
    check("done_pulse_len", 32'(done_o), 32'd0);
    check("done_latency", 32'(doneLatency), 32'd1);
    check("txn_count", 32'(obsQ.size()), 32'(expQ.size()));
    check("protocol", 32'(protoErrs - protoBase), 32'd0);
    nCmp = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < nCmp; i++) begin
      check($sformatf("we[%0d]", i), 32'(obsQ[i].we), 32'(expQ[i].we));
      check($sformatf("addr[%0d]", i), obsQ[i].addr, expQ[i].addr);
      if (expQ[i].we) check($sformatf("dat[%0d]", i), obsQ[i].dat, expQ[i].dat);
    end
    $display("op %0d addr %h wdata %h: %0d txns err %b tmo %b status %h",
             op, addr, wdata, obsQ.size(), err_o, tmo_o, status_o);
  endtask

  task automatic checkResetValues();
    check("rst_active", 32'(bus.m_active_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_tmo", 32'(tmo_o), 32'd0);
    check("rst_status", 32'(status_o), 32'd0);
    check("rst_we", 32'(bus.m_we_o), 32'd0);
    check("rst_addr", bus.m_addr_o, 32'd0);
    check("rst_dat", bus.m_dat_o, 32'd0);
    check("rst_sel", 32'(bus.m_sel_o), 32'hF);
  endtask

  initial begin
    bit          seen;
    logic [1:0]  rop;
    logic [31:0] w;
    int          nr;

    rst = 1'b1;
    start_i = 1'b0;
    op_i = 2'd0;
    addr_i = 32'h0;
    wdata_i = 32'h0;
    repeat (3) @(negedge clk);
    checkResetValues();
    rst = 1'b0;

    // Read-array restore, slow responder.
    stimStat.delete();
    runOp(2'd0, 32'h0000_1000, 32'h0, 4, -1);

    // Program: two not-ready polls then ready.
    stimStat = '{32'h0, 32'h0, 32'h0080_0080};
    runOp(2'd1, 32'h0000_0206, 32'hDEAD_BEEF, 1, -1);

    // Erase with high-chip erase error.
    stimStat = '{32'h00A0_0080};
    runOp(2'd2, 32'h0002_0000, 32'h0, 2, -1);

    // Never ready: poll timeout.
    stimStat.delete();
    runOp(2'd1, 32'h0000_4000, 32'h1234_5678, 0, -1);

    // Second start while busy must be dropped.
    stimStat = '{32'h0, 32'h0080_0080};
    runOp(2'd1, 32'h0000_0010, 32'hCAFE_F00D, 2, 3);

    // Status read never reports an error.
    stimStat = '{32'h003A_003A};
    runOp(2'd3, 32'h0000_0100, 32'h0, 1, -1);

    // Randomized ops.
    for (int t = 0; t < 16; t++) begin
      rop = 2'($urandom);
      stimStat.delete();
      if (rop == 2'd3) begin
        stimStat.push_back($urandom);
      end else begin
        nr = $urandom_range(0, 6);
        for (int j = 0; j < nr; j++) begin
          w = $urandom & ~32'h003A_003A;
          if ($urandom_range(0, 1) == 0) w[7] = 1'b0;
          else w[23] = 1'b0;
          stimStat.push_back(w);
        end
        w = $urandom | 32'h0080_0080;
        if ($urandom_range(0, 1) == 0) w = w & ~32'h003A_003A;
        stimStat.push_back(w);
      end
      runOp(rop, $urandom, $urandom, $urandom_range(0, 4), -1);
    end

    // Reset in the middle of a status poll.
    stimStat.delete();
    statQ.delete();
    ackDelay = 2;
    @(negedge clk);
    start_i = 1'b1;
    op_i = 2'd1;
    addr_i = 32'h0000_8000;
    wdata_i = 32'h5555_AAAA;
    @(negedge clk);
    start_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (bus.m_active_o && !bus.m_we_o) seen = 1'b1;
      else @(negedge clk);
    end
    check("reached_poll", 32'(seen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkResetValues();
    @(negedge clk);
    rst = 1'b0;
    expStatus = 16'h0;

    stimStat.delete();
    runOp(2'd0, 32'h0000_1000, 32'h0, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pkmc_flashprog.md
# pkmc_flashprog

Bus-side command sequencer that drives the PKMC flash controller's request port (address, write data, write enable, `active`, byte select; `ack` back) to perform Intel-style program, block-erase, status-read and read-array-restore operations on the 32-bit flash bank (two x16 devices side by side). A single start pulse launches the whole command sequence. The block polls the status register until ready or timeout, then returns the bank to read-array mode and reports pass/fail to its host (CPU-side register block or boot loader).

## Interface
Parameters:
- `POLL_LIMIT`, default 24'd16000000: maximum status reads per program/erase before timeout.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `start_i` in 1: one-cycle launch strobe; ignored while `busy_o`=1.
- `op_i` in 2: 00 read-array, 01 program word, 10 block erase, 11 read status. Sampled with `start_i`.
- `addr_i` in 32: target byte address, sampled with `start_i`; bits [1:0] ignored.
- `wdata_i` in 32: program data, sampled with `start_i`.
- `busy_o` out 1: sequence in progress.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: result of last op, valid from `done_o` until next start.
- `tmo_o` out 1: last op ended by poll timeout (implies `err_o`).
- `status_o` out 16: last status read, {high-chip SR[7:0], low-chip SR[7:0]}.
- `m_addr_o` out 32: `{addr[31:2],2'b00}`.
- `m_dat_o` out 32: command or data word.
- `m_dat_i` in 32: read data from controller.
- `m_we_o` out 1: 1 = write transaction.
- `m_active_o` out 1: transaction request.
- `m_sel_o` out 4: constant 4'hF.
- `m_ack_i` in 1: transaction acknowledge.

## Operation
- Commands are replicated on both x16 halves: CMD = {8'h00,c,8'h00,c}. Codes: FF read array, 40 program, 20 erase setup, D0 erase confirm, 70 read status, 50 clear status.
- Transaction rule: drive addr/data/we stable with `m_active_o`=1; hold all of them until `m_ack_i` is sampled 1. Drop `m_active_o` for exactly one cycle (GAP), then start the next transaction. Never start a transaction back-to-back with the previous one.
- Read data and status are captured on the `m_ack_i` edge.
- FSM states: IDLE, XFER, GAP, CHECK, DONE. A step pointer selects the current transaction in the sequence:
  - op 00: W FF.
  - op 01: W 40, W wdata, then poll R (status) until ready.
  - op 10: W 20, W D0, then poll R until ready.
  - op 11: W 70, R.
  - Every op except 00 finishes with W 50 (only if error) and then W FF.
- Ready = `m_dat_i[7] & m_dat_i[23]`. Error = any of bits {5,4,3,1} set in either half.
- Poll counter: 24-bit, cleared at start, incremented per status read. If the count reaches `POLL_LIMIT` without ready: set `err_o`=`tmo_o`=1, issue W 50, then W FF.
- op 11 never sets `err_o`; it only updates `status_o`.
- `start_i` while busy is dropped, with no side effect.
- Reset mid-sequence: state goes to IDLE and `m_active_o` drops at the reset edge. The flash may be left in status mode; the host issues op 00.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `err_o`=0, `tmo_o`=0, `status_o`=0, `m_active_o`=0, `m_we_o`=0, `m_addr_o`=0, `m_dat_o`=0, `m_sel_o`=4'hF.
- `start_i` sampled at edge N: `busy_o`=1 and first transaction `m_active_o`=1 from N+1.
- `m_ack_i` sampled at edge M: `m_active_o`=0 during cycle M+1 (GAP), and the next transaction is active from M+2.
- Final transaction ack at edge M: `done_o`=1 and `busy_o`=0 during M+1. `err_o`, `tmo_o` and `status_o` are updated by M+1. A new start is accepted at M+1.
- An `m_ack_i` that arrives while `m_active_o`=0 is ignored.
- Per-op overhead excluding ack waits is 1 cycle per transaction plus 1 cycle.

## Test plan
- Reset, op 00 at 0x0000_1000 (responder acks writes after 4 cycles): one write of 0x00FF00FF at 0x1000, `done_o` 1 cycle after its ack, `err_o`=0.
- Program 0xDEADBEEF at 0x0000_0206: sequence is W 00400040 @0x204, W DEADBEEF @0x204, then status reads. Responder returns 0x00000000 twice, then 0x00800080. Required: exactly 3 reads, then W 00FF00FF, `status_o`=0x8080, `err_o`=0.
- Erase at 0x0002_0000; status returns 0x00A00080 (high-chip bit5 set): W 20, W D0, R, W 00500050, W 00FF00FF; `err_o`=1, `tmo_o`=0, `status_o`=0xA080.
- `POLL_LIMIT`=5, status never ready: exactly 5 reads, then W 50, W FF; `err_o`=`tmo_o`=1.
- Second `start_i` during a program sequence: the transaction count is unchanged. Assert `rst` during a poll read: next cycle `m_active_o`=0, `busy_o`=0, all outputs at reset values. A following op 00 completes normally.
- Gap check across all ops: `m_active_o` is low for exactly 1 cycle between transactions, and addr/data/we never change while `m_active_o`=1 and ack is pending.
